// File: rtl/mem_axi_ctrl.sv
// Load/store sequencer from the CPU memory stage onto an AXI4-lite master port.
// Optional wait-state timeout: define MEM_AXI_TIMEOUT_EN.
module mem_axi_ctrl #(
  parameter logic [2:0]  AXI_PROT       = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, DONE} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;

  logic        req_bad;
  logic [31:0] wdata_fmt;
  logic [3:0]  wstrb_fmt;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        wr_done;
  logic        tmo_hit;

  assign req_ready  = (state_reg == IDLE);
  assign axi_awaddr = {addr_reg[31:2], 2'b00};
  assign axi_araddr = {addr_reg[31:2], 2'b00};
  assign axi_awprot = AXI_PROT;
  assign axi_arprot = AXI_PROT;
  assign axi_wdata  = wdata_reg;
  assign axi_wstrb  = wstrb_reg;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign wr_done = (!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready);

  always_comb begin
    req_bad   = 1'b0;
    wdata_fmt = req_wdata;
    wstrb_fmt = 4'b1111;
    unique case (req_size)
      2'b00: begin
        wdata_fmt = {4{req_wdata[7:0]}};
        wstrb_fmt = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        req_bad   = req_addr[0];
        wdata_fmt = {2{req_wdata[15:0]}};
        wstrb_fmt = 4'b0011 << req_addr[1:0];
      end
      2'b10: req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    rd_shift = axi_rdata >> {addr_reg[1:0], 3'b000};
    unique case (size_reg)
      2'b00:   rd_ext = unsigned_reg ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = unsigned_reg ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

`ifdef MEM_AXI_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        tmo_clear;

  assign tmo_clear = (state_reg == IDLE) || (state_reg == DONE) ||
                     (state_reg == WR && wr_done) || (state_reg == RD_A && axi_arready);
  assign tmo_hit   = (state_reg != IDLE) && (state_reg != DONE) &&
                     (tmo_cnt_reg == TIMEOUT_CYCLES[15:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tmo_cnt_reg <= '0;
    else if (tmo_clear || tmo_hit) tmo_cnt_reg <= '0;
    else                           tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{axi_bresp[0], axi_rresp[0], TIMEOUT_CYCLES[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      axi_awvalid  <= 1'b0;
      axi_wvalid   <= 1'b0;
      axi_bready   <= 1'b0;
      axi_arvalid  <= 1'b0;
      axi_rready   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (tmo_hit) begin
        axi_awvalid <= 1'b0;
        axi_wvalid  <= 1'b0;
        axi_bready  <= 1'b0;
        axi_arvalid <= 1'b0;
        axi_rready  <= 1'b0;
        resp_valid  <= 1'b1;
        resp_err    <= 1'b1;
        resp_rdata  <= '0;
        state_reg   <= DONE;
      end else begin
        unique case (state_reg)
          IDLE: if (req_valid) begin
            addr_reg     <= req_addr;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            wdata_reg    <= wdata_fmt;
            wstrb_reg    <= wstrb_fmt;
            // Bad requests are answered straight away without touching the bus.
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state_reg  <= DONE;
            end else if (req_we) begin
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state_reg   <= WR;
            end else begin
              axi_arvalid <= 1'b1;
              state_reg   <= RD_A;
            end
          end
          WR: begin
            if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
            if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
            if (wr_done) begin
              axi_bready <= 1'b1;
              state_reg  <= WR_B;
            end
          end
          WR_B: if (axi_bvalid) begin
            axi_bready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= axi_bresp[1];
            resp_rdata <= '0;
            state_reg  <= DONE;
          end
          RD_A: if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state_reg   <= RD_D;
          end
          RD_D: if (axi_rvalid) begin
            axi_rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= axi_rresp[1];
            resp_rdata <= axi_rresp[1] ? 32'h0 : rd_ext;
            state_reg  <= DONE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_axi_ctrl.sv
// Randomised bench for mem_axi_ctrl: an in-bench AXI4-lite slave with per-channel
// wait states plus an arithmetic reference model of byte lanes and extension.
module tb_mem_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

  int n_chk = 0;
  int n_err = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  mem_axi_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_slave();
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rresp = 2'b00; axi_rdata = '0;
  endtask

  // Caller must be at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] d,
                         input logic [1:0] size, input logic uns,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly,
                         input logic [1:0] bresp, input logic [1:0] rresp,
                         input logic [31:0] slv_rdata);
    int nbytes, lane, e_lat, hs_max;
    logic bad, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata, val, mask;
    logic [3:0] e_wstrb;
    int aw_wait, w_wait, ar_wait, n_aw, n_w, n_ar, n_b, n_r, both_cyc, ar_hs, resp_cyc, n_resp;
    logic any_axi, unstable, early;
    logic [31:0] got_awaddr, got_wdata, got_araddr, got_rdata;
    logic [3:0] got_wstrb;
    logic got_err;

    // Reference model: lanes, strobes and extension from plain arithmetic.
    nbytes = 1 << size;
    lane   = addr % 4;
    bad    = (size == 2'b11) || ((addr % nbytes) != 0);
    e_addr = addr - lane;
    e_wstrb = 4'(((1 << nbytes) - 1) << lane);
    e_wdata = 0;
    for (int i = 0; i < 4; i++)
      e_wdata = e_wdata | (((d >> (8 * (i % nbytes))) & 32'hFF) << (8 * i));
    val = slv_rdata >> (8 * lane);
    if (nbytes < 4) begin
      mask = (32'd1 << (8 * nbytes)) - 32'd1;
      val  = val & mask;
      if (!uns && val[8 * nbytes - 1]) val = val | ~mask;
    end
    e_err   = bad || (we ? bresp[1] : rresp[1]);
    e_rdata = (!we && !e_err) ? val : 32'h0;
    if (bad) e_lat = 1;
    else if (we) begin
      hs_max = (aw_dly > w_dly) ? aw_dly : w_dly;
      e_lat  = hs_max + 1 + 2 + b_dly;
    end else e_lat = ar_dly + 1 + 2 + r_dly;

    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d;
    req_size = size; req_unsigned = uns;
    @(posedge clk);

    aw_wait = 0; w_wait = 0; ar_wait = 0; n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0;
    both_cyc = -1; ar_hs = -1; resp_cyc = -1; n_resp = 0;
    any_axi = 0; unstable = 0; early = 0;
    got_awaddr = 0; got_wdata = 0; got_wstrb = 0; got_araddr = 0; got_rdata = 0; got_err = 0;

    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (axi_awvalid || axi_wvalid || axi_arvalid || axi_bready || axi_rready) any_axi = 1;
      if (resp_valid) begin
        n_resp++;
        if (resp_cyc < 0) begin
          resp_cyc = cyc; got_err = resp_err; got_rdata = resp_rdata;
        end
      end
      if (resp_cyc >= 0 && cyc == resp_cyc + 1) begin
        check("ready_after_resp", req_ready, 1);
        break;
      end
      if (axi_awvalid && axi_awaddr !== e_addr) unstable = 1;
      if (axi_wvalid && (axi_wdata !== e_wdata || axi_wstrb !== e_wstrb)) unstable = 1;
      if (axi_arvalid && axi_araddr !== e_addr) unstable = 1;
      if (axi_bready && !(both_cyc >= 0 && cyc > both_cyc)) early = 1;
      if (axi_rready && !(ar_hs >= 0 && cyc > ar_hs)) early = 1;

      // Slave response for this cycle; handshakes complete at the coming posedge.
      axi_awready = axi_awvalid && (aw_wait >= aw_dly);
      if (axi_awvalid && !axi_awready) aw_wait++;
      if (axi_awvalid && axi_awready) begin n_aw++; got_awaddr = axi_awaddr; end
      axi_wready = axi_wvalid && (w_wait >= w_dly);
      if (axi_wvalid && !axi_wready) w_wait++;
      if (axi_wvalid && axi_wready) begin n_w++; got_wdata = axi_wdata; got_wstrb = axi_wstrb; end
      if (n_aw > 0 && n_w > 0 && both_cyc < 0) both_cyc = cyc;
      axi_bresp  = bresp;
      axi_bvalid = (both_cyc >= 0) && (cyc >= both_cyc + 1 + b_dly) && (n_b == 0);
      if (axi_bvalid && axi_bready) n_b++;

      axi_arready = axi_arvalid && (ar_wait >= ar_dly);
      if (axi_arvalid && !axi_arready) ar_wait++;
      if (axi_arvalid && axi_arready) begin n_ar++; ar_hs = cyc; got_araddr = axi_araddr; end
      axi_rresp  = rresp;
      axi_rdata  = slv_rdata;
      axi_rvalid = (ar_hs >= 0) && (cyc >= ar_hs + 1 + r_dly) && (n_r == 0);
      if (axi_rvalid && axi_rready) n_r++;

      // Requests offered while busy must be ignored.
      if (resp_cyc < 0) begin
        req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
      end else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    clear_slave();

    check("resp_seen", (resp_cyc >= 0), 1);
    check("resp_count", n_resp, 1);
    check("resp_latency", resp_cyc, e_lat);
    check("resp_err", got_err, e_err);
    check("resp_rdata", got_rdata, e_rdata);
    if (bad) check("no_axi_on_bad", any_axi, 0);
    else if (we) begin
      check("aw_hs_count", n_aw, 1);
      check("w_hs_count", n_w, 1);
      check("b_hs_count", n_b, 1);
      check("awaddr", got_awaddr, e_addr);
      check("wdata", got_wdata, e_wdata);
      check("wstrb", got_wstrb, e_wstrb);
      check("wr_stable", unstable, 0);
      check("bready_order", early, 0);
    end else begin
      check("ar_hs_count", n_ar, 1);
      check("r_hs_count", n_r, 1);
      check("araddr", got_araddr, e_addr);
      check("ar_stable", unstable, 0);
      check("rready_order", early, 0);
    end
    n_txn++;
    $display("txn %0d we=%0b addr=%h size=%0d uns=%0b err=%0b rdata=%h lat=%0d",
             n_txn, we, addr, size, uns, got_err, got_rdata, resp_cyc);
  endtask

  initial begin
    logic saw_resp;
    logic [1:0] sz;
    logic [31:0] a;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0;
    clear_slave();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
    check("rst_resp", {resp_valid, resp_err}, 0);
    check("rst_rdata", resp_rdata, 0);
    check("prot", {axi_awprot, axi_arprot}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_txn(1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    run_txn(0, 32'h0000_2002, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8001_1234);
    run_txn(0, 32'h0000_2002, 0, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8001_1234);
    run_txn(1, 32'h0000_3000, 32'h1234_5678, 2'b10, 0, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    run_txn(0, 32'h0000_3002, 0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF);
    run_txn(0, 32'h0000_3000, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF);
    run_txn(1, 32'h0000_3001, 32'hFFFF, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    run_txn(1, 32'h0000_4000, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
    run_txn(0, 32'h0000_4000, 0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h1357_9BDF);
    run_txn(0, 32'h0000_5001, 0, 2'b00, 0, 0, 0, 0, 2, 1, 2'b00, 2'b00, 32'h0000_8000);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
      run_txn(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'b00,
              ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'b00,
              $urandom);
    end

    // Reset while a read address phase is stalled.
    check("ready_before_rst_txn", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000; req_size = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("arvalid_before_rst", axi_arvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arvalid_in_rst", axi_arvalid, 0);
    check("ready_in_rst", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("no_resp_after_rst", saw_resp, 0);
    run_txn(0, 32'h0000_7001, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_A500);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
